// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing defaults, colour codes, counter widths.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package vga_pkg;

  // 640x480@60 raster, 25 MHz pixel rate derived from a 100 MHz clock
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 4;
  localparam int COLOR_W_DEF   = 4;

  // Colour codes as {B,G,R} bit masks; a colour-bar index decodes directly against these
  localparam logic [2:0] RED_   = 3'b001;
  localparam logic [2:0] GREEN_ = 3'b010;
  localparam logic [2:0] BLUE_  = 3'b100;

  // Counter width for a modulus, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int hcw(input int h_total);
    return cnt_w(h_total);
  endfunction

  function automatic int vcw(input int v_total);
    return cnt_w(v_total);
  endfunction

endpackage

// File: rtl/pixel_ce_gen.sv
// Pixel clock-enable divider: one-clock strobe every CLK_DIV system clocks.
// Latency: first strobe CLK_DIV clocks after reset release; strobe is combinational from the divider.
// Backpressure: none, free-running.
// Ports: clk (system clock), reset (sync, active-high), pix_ce (strobe, low while reset is high).
module pixel_ce_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_ce
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // With CLK_DIV == 1 the divider sits at 0 == DIV_LAST and the strobe is continuous.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign pix_ce = !reset && (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered sync/blank and blanked RGB.
// Latency: sync, visenable and RGB lag hcount/vcount by one pixel (CLK_DIV clocks), mutually aligned.
// Backpressure: none; the colour source must answer within one pixel period.
// Ports: clk100MHz, reset (sync active-high); pix_r/g/b colour in for (hcount,vcount);
//   pattern_sel (used only with TEST_PATTERN_EN defined); hcount/vcount, pix_ce, line_start,
//   frame_start timing outputs; hsynch/vsynch/visenable and Rout/Gout/Bout registered outputs.
// Build option: define TEST_PATTERN_EN to add an internal 8-bar colour pattern selected by pattern_sel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int COLOR_W   = COLOR_W_DEF
) (
  input  logic                clk100MHz,
  input  logic                reset,
  input  logic [COLOR_W-1:0]  pix_r,
  input  logic [COLOR_W-1:0]  pix_g,
  input  logic [COLOR_W-1:0]  pix_b,
  input  logic                pattern_sel,
  output logic [hcw(H_VISIBLE+H_FRONT+H_SYNC+H_BACK)-1:0] hcount,
  output logic [vcw(V_VISIBLE+V_FRONT+V_SYNC+V_BACK)-1:0] vcount,
  output logic                pix_ce,
  output logic                line_start,
  output logic                frame_start,
  output logic                hsynch,
  output logic                vsynch,
  output logic                visenable,
  output logic [COLOR_W-1:0]  Rout,
  output logic [COLOR_W-1:0]  Gout,
  output logic [COLOR_W-1:0]  Bout
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HCW      = hcw(H_TOTAL);
  localparam int VCW      = vcw(V_TOTAL);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC - 1;

  pixel_ce_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_ce_gen (
    .clk     (clk100MHz),
    .reset   (reset),
    .pix_ce  (pix_ce)
  );

  // Raster counters; the line wrap and frame wrap land in the same update.
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_ce) begin
      if (hcount == HCW'(H_TOTAL - 1)) begin
        hcount <= '0;
        if (vcount == VCW'(V_TOTAL - 1)) begin
          vcount <= '0;
        end else begin
          vcount <= vcount + VCW'(1);
        end
      end else begin
        hcount <= hcount + HCW'(1);
      end
    end
  end

  assign line_start  = pix_ce && (hcount == '0);
  assign frame_start = line_start && (vcount == '0);

  logic hs_act;
  logic vs_act;
  logic vis;

  assign hs_act = (hcount >= HCW'(HS_START)) && (hcount <= HCW'(HS_END));
  assign vs_act = (vcount >= VCW'(VS_START)) && (vcount <= VCW'(VS_END));
  assign vis    = (hcount < HCW'(H_VISIBLE)) && (vcount < VCW'(V_VISIBLE));

  // Colour source selection
  logic [COLOR_W-1:0] src_r;
  logic [COLOR_W-1:0] src_g;
  logic [COLOR_W-1:0] src_b;

`ifdef TEST_PATTERN_EN
  // Bar index hcount*8/H_VISIBLE; only meaningful while visible, blanking hides the rest.
  logic [2:0] bar;
  assign bar = 3'((32'(hcount) * 32'd8) / 32'(H_VISIBLE));

  always_comb begin
    src_r = pix_r;
    src_g = pix_g;
    src_b = pix_b;
    if (pattern_sel) begin
      src_r = {COLOR_W{|(bar & RED_)}};
      src_g = {COLOR_W{|(bar & GREEN_)}};
      src_b = {COLOR_W{|(bar & BLUE_)}};
    end
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;

  assign src_r = pix_r;
  assign src_g = pix_g;
  assign src_b = pix_b;
`endif

  // One-pixel output register; holds between strobes so the pipeline stays aligned.
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      hsynch    <= ~HS_POL;
      vsynch    <= ~VS_POL;
      visenable <= 1'b0;
      Rout      <= '0;
      Gout      <= '0;
      Bout      <= '0;
    end else if (pix_ce) begin
      hsynch    <= hs_act ? HS_POL : ~HS_POL;
      vsynch    <= vs_act ? VS_POL : ~VS_POL;
      visenable <= vis;
      Rout      <= vis ? src_r : '0;
      Gout      <= vis ? src_g : '0;
      Bout      <= vis ? src_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default 640x480/div4, tiny div1 active-high sync,
// small div4) checked cycle by cycle against a raster model computed from the elapsed clock count.
// Observations are taken on the falling clock edge; inputs change on the falling edge.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] pix_r = 4'h0;
  logic [3:0] pix_g = 4'h0;
  logic [3:0] pix_b = 4'h0;
  logic       pattern_sel = 1'b0;

  int checks = 0;
  int errors = 0;
  bit fixed_col = 1'b0;

`ifdef TEST_PATTERN_EN
  wire pat_on = pattern_sel;
`else
  wire pat_on = 1'b0;
`endif

  // Instance 0: defaults
  logic [9:0] hc0, vc0;
  logic       ce0, ls0, fs0, hs0, vs0, ve0;
  logic [3:0] r0, g0, b0;
  vga_timing_gen dut0 (
    .clk100MHz(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pattern_sel(pattern_sel), .hcount(hc0), .vcount(vc0), .pix_ce(ce0),
    .line_start(ls0), .frame_start(fs0), .hsynch(hs0), .vsynch(vs0),
    .visenable(ve0), .Rout(r0), .Gout(g0), .Bout(b0)
  );

  // Instance 1: tiny raster, CLK_DIV=1, active-high syncs
  logic [3:0] hc1;
  logic [2:0] vc1;
  logic       ce1, ls1, fs1, hs1, vs1, ve1;
  logic [3:0] r1, g1, b1;
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(2), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4)
  ) dut1 (
    .clk100MHz(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pattern_sel(pattern_sel), .hcount(hc1), .vcount(vc1), .pix_ce(ce1),
    .line_start(ls1), .frame_start(fs1), .hsynch(hs1), .vsynch(vs1),
    .visenable(ve1), .Rout(r1), .Gout(g1), .Bout(b1)
  );

  // Instance 2: small raster, CLK_DIV=4, active-low syncs
  logic [4:0] hc2;
  logic [3:0] vc2;
  logic       ce2, ls2, fs2, hs2, vs2, ve2;
  logic [3:0] r2, g2, b2;
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(4), .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4)
  ) dut2 (
    .clk100MHz(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pattern_sel(pattern_sel), .hcount(hc2), .vcount(vc2), .pix_ce(ce2),
    .line_start(ls2), .frame_start(fs2), .hsynch(hs2), .vsynch(vs2),
    .visenable(ve2), .Rout(r2), .Gout(g2), .Bout(b2)
  );

  typedef struct packed {
    logic        ce, ls, fs, hs, vs, ve;
    logic [11:0] hc, vc;
    logic [3:0]  r, g, b;
  } obs_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, d;
    bit hp, vp;
  } cfg_t;

  function automatic cfg_t cfg_of(input int i);
    cfg_t c;
    case (i)
      0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0};
      1:       c = '{8, 2, 2, 2, 2, 2, 2, 2, 1, 1'b1, 1'b1};
      default: c = '{16, 2, 3, 3, 6, 1, 2, 1, 4, 1'b0, 1'b0};
    endcase
    return c;
  endfunction

  function automatic obs_t observe(input int i);
    obs_t o;
    case (i)
      0:       o = {ce0, ls0, fs0, hs0, vs0, ve0, 12'(hc0), 12'(vc0), r0, g0, b0};
      1:       o = {ce1, ls1, fs1, hs1, vs1, ve1, 12'(hc1), 12'(vc1), r1, g1, b1};
      default: o = {ce2, ls2, fs2, hs2, vs2, ve2, 12'(hc2), 12'(vc2), r2, g2, b2};
    endcase
    return o;
  endfunction

  // Expected outputs after n clock edges out of reset: p = pixels elapsed, outputs describe pixel p-1.
  function automatic obs_t model(input int i, input longint n, input logic [11:0] col, input bit pat);
    cfg_t   c  = cfg_of(i);
    longint ht = c.hv + c.hf + c.hs + c.hb;
    longint vt = c.vv + c.vf + c.vs + c.vb;
    longint p  = n / c.d;
    longint q, qh, qv;
    logic [2:0] bar;
    obs_t e;
    e    = '0;
    e.ce = ((n % c.d) == c.d - 1);
    e.hc = 12'(p % ht);
    e.vc = 12'((p / ht) % vt);
    e.ls = e.ce && ((p % ht) == 0);
    e.fs = e.ls && (((p / ht) % vt) == 0);
    e.hs = ~c.hp;
    e.vs = ~c.vp;
    if (p > 0) begin
      q  = p - 1;
      qh = q % ht;
      qv = (q / ht) % vt;
      if (qh >= c.hv + c.hf && qh < c.hv + c.hf + c.hs) e.hs = c.hp;
      if (qv >= c.vv + c.vf && qv < c.vv + c.vf + c.vs) e.vs = c.vp;
      e.ve = (qh < c.hv) && (qv < c.vv);
      if (e.ve) begin
        if (pat) begin
          bar = 3'((qh * 8) / c.hv);
          e.r = bar[0] ? 4'hF : 4'h0;
          e.g = bar[1] ? 4'hF : 4'h0;
          e.b = bar[2] ? 4'hF : 4'h0;
        end else begin
          {e.r, e.g, e.b} = col;
        end
      end
    end
    return e;
  endfunction

  function automatic obs_t reset_exp(input int i);
    obs_t e;
    e    = model(i, 0, 12'h000, 1'b0);
    e.ce = 1'b0;
    e.ls = 1'b0;
    e.fs = 1'b0;
    return e;
  endfunction

  // Drive a new colour; remember it when the next edge is the one that samples it.
  task automatic next_col(input int i, input longint n, inout logic [11:0] col);
    cfg_t c = cfg_of(i);
    if (!fixed_col) {pix_r, pix_g, pix_b} = 12'($urandom);
    if ((n % c.d) == c.d - 1) col = {pix_r, pix_g, pix_b};
  endtask

  // Called on a falling edge with reset high: releases it, edge count restarts at 0.
  task automatic release_rst(input int i, output longint n, inout logic [11:0] col);
    reset = 1'b0;
    n     = 0;
    next_col(i, n, col);
  endtask

  task automatic step(input int i, inout longint n, inout logic [11:0] col, output obs_t o, output obs_t e);
    @(posedge clk);
    n++;
    @(negedge clk);
    o = observe(i);
    e = model(i, n, col, pat_on);
    next_col(i, n, col);
  endtask

  task automatic test_reset();
    obs_t o, e;
    repeat (3) begin
      @(negedge clk);
      {pix_r, pix_g, pix_b} = 12'($urandom);
      for (int i = 0; i < 3; i++) begin
        o = observe(i);
        e = reset_exp(i);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL reset inst%0d: got %h expected %h", i, o, e);
        end
      end
    end
  endtask

  task automatic test_default_lines();
    longint n;
    logic [11:0] col = 12'hA5F;
    obs_t o, e;
    logic prev_hs = 1'b1;
    longint fall[$];
    longint rise[$];
    int vis_px = 0;
    fixed_col = 1'b1;
    pattern_sel = 1'b0;
    {pix_r, pix_g, pix_b} = 12'hA5F;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); release_rst(0, n, col);
    repeat (6400) begin
      step(0, n, col, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL default_raster n=%0d: got %h expected %h", n, o, e);
      end
      if (prev_hs && !o.hs) fall.push_back(n);
      if (!prev_hs && o.hs) rise.push_back(n);
      prev_hs = o.hs;
      if (n < 3200 && o.ce && o.ve && {o.r, o.g, o.b} == 12'hA5F) vis_px++;
    end
    checks++;
    if (fall.size() != 2 || rise.size() < 1) begin
      errors++;
      $display("FAIL hsync_edges: got %0d falls %0d rises, expected 2 falls and at least 1 rise", fall.size(), rise.size());
    end else begin
      checks++;
      if (fall[1] - fall[0] != 3200) begin
        errors++;
        $display("FAIL hsync_period: got %0d clks expected 3200", fall[1] - fall[0]);
      end
      checks++;
      if (rise[0] - fall[0] != 384) begin
        errors++;
        $display("FAIL hsync_low: got %0d clks expected 384", rise[0] - fall[0]);
      end
    end
    checks++;
    if (vis_px != 640) begin
      errors++;
      $display("FAIL visible_pixels_line0: got %0d expected 640", vis_px);
    end
    fixed_col = 1'b0;
  endtask

  task automatic test_small_frames();
    longint n;
    logic [11:0] col = 12'h000;
    obs_t o, e;
    int fs_cnt = 0;
    int ls_cnt = 0;
    logic prev_act = 1'b0;
    longint on[$];
    longint off[$];
    pattern_sel = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); release_rst(1, n, col);
    repeat (4 * 112) begin
      step(1, n, col, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL tiny_raster n=%0d: got %h expected %h", n, o, e);
      end
      if (o.fs) fs_cnt++;
      if (o.ls) ls_cnt++;
      if (!prev_act && o.vs) on.push_back(n);
      if (prev_act && !o.vs) off.push_back(n);
      prev_act = o.vs;
    end
    checks++;
    if (fs_cnt != 4) begin
      errors++;
      $display("FAIL tiny_frame_start_count: got %0d expected 4", fs_cnt);
    end
    checks++;
    if (ls_cnt != 32) begin
      errors++;
      $display("FAIL tiny_line_start_count: got %0d expected 32", ls_cnt);
    end
    checks++;
    if (on.size() < 2 || off.size() < 1) begin
      errors++;
      $display("FAIL tiny_vsync_edges: got %0d starts %0d ends", on.size(), off.size());
    end else begin
      checks++;
      if (on[1] - on[0] != 112 || off[0] - on[0] != 28) begin
        errors++;
        $display("FAIL tiny_vsync_timing: got period %0d active %0d expected 112 and 28", on[1] - on[0], off[0] - on[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    longint n;
    logic [11:0] col = 12'h000;
    obs_t o, e;
    bit reached = 1'b0;
    int k = 0;
    pattern_sel = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); release_rst(0, n, col);
    for (int s = 0; s < 20000 && !reached; s++) begin
      step(0, n, col, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midreset_walk n=%0d: got %h expected %h", n, o, e);
      end
      if (e.hc == 12'd300 && e.vc == 12'd1) reached = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o = observe(0);
    e = reset_exp(0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL midreset_state: got %h expected %h", o, e);
    end
    reset = 1'b0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (hc0 == 10'd0 && k < 20);
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL midreset_first_pixel: got %0d clks expected 4", k);
    end
  endtask

  task automatic test_back_to_back_frames();
    longint n;
    logic [11:0] col = 12'h000;
    obs_t o, e;
    int fs_cnt = 0;
    int pre = 300 + int'($urandom_range(600));
    pattern_sel = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); release_rst(2, n, col);
    repeat (pre) begin
      step(2, n, col, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL small_pre n=%0d: got %h expected %h", n, o, e);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o = observe(2);
    e = reset_exp(2);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL small_reset_state: got %h expected %h", o, e);
    end
    release_rst(2, n, col);
    repeat (3 * 960) begin
      step(2, n, col, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL small_raster n=%0d: got %h expected %h", n, o, e);
      end
      if (o.fs) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 3) begin
      errors++;
      $display("FAIL small_frame_start_count: got %0d expected 3", fs_cnt);
    end
  endtask

  task automatic test_pattern();
    longint n;
    logic [11:0] col = 12'h000;
    obs_t o, e;
    pattern_sel = 1'b1;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); release_rst(0, n, col);
    repeat (3300) begin
      step(0, n, col, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pattern_raster n=%0d: got %h expected %h", n, o, e);
      end
    end
    pattern_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_lines();
    test_small_frames();
    test_reset_mid_frame();
    test_back_to_back_frames();
    test_pattern();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Generates the pixel-clock enable, the h/v counters, registered sync/blank signals and a blanked, pipeline-aligned RGB output. Replaces the fixed 640x480 counter plus sync-decode pair. Sits between the 100 MHz system clock and the colour source, e.g. the snake renderer. The source reads the exported coordinates and returns a colour within one pixel period.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, h front porch (pixels)
H_SYNC, 96, h sync width (pixels)
H_BACK, 48, h back porch (pixels)
V_VISIBLE, 480, active lines
V_FRONT, 10, v front porch (lines)
V_SYNC, 2, v sync width (lines)
V_BACK, 33, v back porch (lines)
CLK_DIV, 4, system clocks per pixel (>=1)
HS_POL, 0, hsynch active level
VS_POL, 0, vsynch active level
COLOR_W, 4, bits per colour channel

Ports:
clk100MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_r, pix_g, pix_b  in  COLOR_W each  colour for the current (hcount, vcount)
pattern_sel  in  1  selects the test pattern; only used when TEST_PATTERN_EN is defined
hcount  out  HCW = $clog2(H_TOTAL)  current pixel column (counter value)
vcount  out  VCW = $clog2(V_TOTAL)  current line (counter value)
pix_ce  out  1  one-clk pixel strobe
line_start  out  1  one-clk pulse: pix_ce && hcount==0
frame_start  out  1  one-clk pulse: pix_ce && hcount==0 && vcount==0
hsynch, vsynch  out  1  registered sync outputs
visenable  out  1  registered active-video flag
Rout, Gout, Bout  out  COLOR_W each  registered, blanked colour

Behaviour:
- Interface: one clock, clk100MHz; reset is synchronous and active-high, sampled on the clk100MHz rising edge.
- Derived constants: H_TOTAL = sum of the H_* parameters (default 800). V_TOTAL = sum of the V_* parameters (default 525).
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_ce = (div == CLK_DIV-1). With CLK_DIV == 1, pix_ce is constantly 1 outside reset.
- Counters advance only on pix_ce:
  - hcount == H_TOTAL-1: hcount <= 0, and vcount increments.
  - vcount == V_TOTAL-1 at that point: vcount <= 0.
- Sync decode from the counter values:
  - hs_act when H_VISIBLE+H_FRONT <= hcount <= H_VISIBLE+H_FRONT+H_SYNC-1 (default 656..751).
  - vs_act when V_VISIBLE+V_FRONT <= vcount <= V_VISIBLE+V_FRONT+V_SYNC-1 (default 490..491).
  - vis = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
- Output register, updated only on pix_ce:
  - hsynch <= hs_act ? HS_POL : ~HS_POL; vsynch likewise with VS_POL.
  - visenable <= vis.
  - R/G/B <= vis ? pix_* : 0.
- Latency: hsynch, vsynch, visenable and RGB lag hcount/vcount by exactly one pixel (CLK_DIV clocks) and are mutually aligned. pix_* is sampled on the same clk edge on which pix_ce is high. The source therefore has CLK_DIV-1 clocks of settling after the counters change.
- Outputs hold between pix_ce strobes.
- Reset values:
  - div=0, hcount=0, vcount=0.
  - hsynch=~HS_POL, vsynch=~VS_POL.
  - visenable=0, RGB=0.
  - pix_ce, line_start and frame_start are 0 during reset.
- Reset mid-frame: all registers return to their reset values on the next edge. The first pix_ce occurs CLK_DIV clocks after reset deasserts. A partial frame is abandoned with no glitch beyond the forced inactive sync levels.
- Boundaries: hcount never exceeds H_TOTAL-1 and vcount never exceeds V_TOTAL-1. A line wrap and a frame wrap on the same pix_ce is a single coherent update to (0,0).

Optional Feature:
TEST_PATTERN_EN
- Defined: when pattern_sel=1, the colour source is an internal 8-bar pattern. Bar index = hcount*8/H_VISIBLE, i.e. bits {B,G,R} of the index, giving the order black, red, green, yellow, blue, magenta, cyan, white. Each channel is all-ones or zero. Blanking and latency are unchanged.
- Not defined: pattern_sel is ignored, the pattern logic is absent, and pix_* is always used.

Decomposition:
- Shared package vga_pkg: the 640x480@60 timing constants, the colour-code constants (the existing RED_/GREEN_/BLUE_ colour codes), and the HCW/VCW width functions.
- One natural sub-module, pixel_ce_gen: the CLK_DIV divider producing pix_ce.

Test Plan:
- Defaults, release reset, run 2 frames → hsynch period 3200 clks, low for 384 clks; vsynch period 1,680,000 clks, low for 2 lines (6400 clks).
- pix_r=4'hA, pix_g=4'h5, pix_b=4'hF held → RGB = A/5/F exactly while visenable=1 (640 px per line, 480 lines); RGB = 0 elsewhere, including at hcount=0 in the cycle right after line 479's last pixel.
- Check frame_start → exactly one clk-wide pulse per frame, coincident with hcount=0 and vcount=0; line_start 525 times per frame.
- Assert reset at hcount=300, vcount=200 for 1 clk → next edge: counters 0, hsynch=1, vsynch=1, RGB=0; first pix_ce 4 clks after release.
- CLK_DIV=1, H_VISIBLE=8, H_FRONT=H_SYNC=H_BACK=2, V_*=2, HS_POL=VS_POL=1 → pix_ce always 1; hsynch high for hcount 10..11 (delayed 1 clk); line wraps at 13.
- TEST_PATTERN_EN defined, pattern_sel=1 → hcount 0..79 outputs 0/0/0, hcount 80..159 outputs F/0/0, hcount 560..639 outputs F/F/F.
